mem_vio_report_queue: RTL and testbench

- Collects memory-order violation reports from the load pipelines (load/store address-overlap check) and trains the store-set predictor in memDepPred.
- Per cycle, keeps only the oldest violating load among the reports, buffers it in a small circular queue, and drains one training update per cycle.
- Output connects directly to the memDepPred violation inputs.
- Reports from squashed (wrong-path) loads are discarded before they can train the predictor.

---
 rtl/mem_vio_report_queue_pkg.sv | 33 +++
 rtl/mem_vio_report_queue_oldest_select.sv | 36 +++
 rtl/mem_vio_report_queue.sv | 143 ++++++++++++++
 tb/tb_mem_vio_report_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_vio_report_queue_pkg.sv
// Shared backend types for memory-order violation reporting: ROB index type,
// age comparison and the violation queue entry.
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 10
`endif

package mem_vio_report_queue_pkg;

  localparam int ROB_IDX_W    = 6;
  localparam int FOLDPC_W_DEF = `MEMDEP_FOLDPC_WIDTH;

  // flg toggles on every ROB wrap, so the index order flips when flags differ.
  typedef struct packed {
    logic                 flg;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    logic                    vld;
    robIdx_t                 load_robIdx;
    logic [FOLDPC_W_DEF-1:0] load_foldpc;
    logic [FOLDPC_W_DEF-1:0] store_foldpc;
  } memvio_entry_t;

  // True when a is strictly older than b.
  function automatic logic rob_older(robIdx_t a, robIdx_t b);
    if (a.flg == b.flg) begin
      return (a.idx < b.idx);
    end
    return (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/mem_vio_report_queue_oldest_select.sv
// N-way age select: returns the port holding the oldest valid ROB index,
// lowest port winning on equal indices.
module mem_vio_report_queue_oldest_select
  import mem_vio_report_queue_pkg::*;
#(
  parameter  int N     = 2,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                [N-1:0] vld,
  input  robIdx_t             [N-1:0] rob,
  output logic                        sel_vld,
  output logic [SEL_W-1:0]            sel_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;
  robIdx_t          best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    // Strict "older" keeps the earlier port on ties.
    for (int i = 0; i < N; i++) begin
      if (vld[i] && (!found || rob_older(rob[i], best))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
        best  = rob[i];
      end
    end
  end

  assign sel_vld = found;
  assign sel_idx = idx;

endmodule

// File: rtl/mem_vio_report_queue.sv
// Violation report queue feeding memDepPred training; keeps the oldest report
// per cycle. Optional MEMVIO_DEDUP_EN drops reports whose PC pair is already queued.
module mem_vio_report_queue
  import mem_vio_report_queue_pkg::*;
#(
  parameter int NUM_REPORT = 2,
  parameter int DEPTH      = 4,
  parameter int FOLDPC_W   = `MEMDEP_FOLDPC_WIDTH,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REPORT-1:0]                i_rpt_vld,
  input  robIdx_t [NUM_REPORT-1:0]             i_rpt_load_robIdx,
  input  logic [NUM_REPORT-1:0][FOLDPC_W-1:0]  i_rpt_load_foldpc,
  input  logic [NUM_REPORT-1:0][FOLDPC_W-1:0]  i_rpt_store_foldpc,
  input  logic                                 i_squash,
  input  robIdx_t                              i_squash_robIdx,
  output logic                                 o_vio_vld,
  input  logic                                 i_vio_rdy,
  output logic [FOLDPC_W-1:0]                  o_vio_load_foldpc,
  output logic [FOLDPC_W-1:0]                  o_vio_store_foldpc,
  output logic                                 o_full,
  output logic [CNT_W-1:0]                     o_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEL_W = (NUM_REPORT > 1) ? $clog2(NUM_REPORT) : 1;
  localparam int INC_W = $clog2(NUM_REPORT + 1);

  memvio_entry_t    q_reg [DEPTH];
  logic [PTR_W:0]   head_reg, tail_reg;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic [PTR_W-1:0] head_idx, tail_idx;
  logic             empty, full, pop, skip, deq, enq, dup;
  memvio_entry_t    head_ent, new_entry;

  assign head_idx = head_reg[PTR_W-1:0];
  assign tail_idx = tail_reg[PTR_W-1:0];
  assign empty    = (head_reg == tail_reg);
  assign full     = (head_reg[PTR_W] != tail_reg[PTR_W]) && (head_idx == tail_idx);
  assign head_ent = q_reg[head_idx];

  assign o_vio_vld          = !empty && head_ent.vld;
  assign o_vio_load_foldpc  = head_ent.load_foldpc;
  assign o_vio_store_foldpc = head_ent.store_foldpc;
  assign o_full             = full;
  assign o_drop_cnt         = drop_cnt_reg;

  assign pop  = o_vio_vld && i_vio_rdy;
  assign skip = !empty && !head_ent.vld;
  // A squashed head slot is freed like a pop, so it can also make room for a write.
  assign deq  = pop || skip;

  // Reports from the wrong path vanish silently; they are not drops.
  logic [NUM_REPORT-1:0] live;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REPORT; gi++) begin : g_live
      assign live[gi] = i_rpt_vld[gi] &&
                        !(i_squash && rob_older(i_squash_robIdx, i_rpt_load_robIdx[gi]));
    end
  endgenerate

  logic             sel_vld;
  logic [SEL_W-1:0] sel_idx;

  mem_vio_report_queue_oldest_select #(.N(NUM_REPORT)) u_oldest_select (
    .vld     (live),
    .rob     (i_rpt_load_robIdx),
    .sel_vld (sel_vld),
    .sel_idx (sel_idx)
  );

  always_comb begin
    new_entry              = '0;
    new_entry.vld          = 1'b1;
    new_entry.load_robIdx  = i_rpt_load_robIdx[sel_idx];
    new_entry.load_foldpc  = i_rpt_load_foldpc[sel_idx];
    new_entry.store_foldpc = i_rpt_store_foldpc[sel_idx];
  end

`ifdef MEMVIO_DEDUP_EN
  logic [DEPTH-1:0] dup_hit;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dup
      assign dup_hit[gi] = q_reg[gi].vld &&
                           (q_reg[gi].load_foldpc == new_entry.load_foldpc) &&
                           (q_reg[gi].store_foldpc == new_entry.store_foldpc);
    end
  endgenerate
  assign dup = |dup_hit;
`else
  assign dup = 1'b0;
`endif

  assign enq = sel_vld && !dup && (!full || deq);

  // Every live report that is not written is a drop: losers, overflow, duplicates.
  logic [INC_W-1:0] drop_inc;
  logic [CNT_W:0]   drop_sum;
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_REPORT; i++) begin
      drop_inc = drop_inc + INC_W'(live[i]);
    end
    drop_inc      = drop_inc - INC_W'(enq);
    drop_sum      = {1'b0, drop_cnt_reg} + (CNT_W + 1)'(drop_inc);
    drop_cnt_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  logic [DEPTH-1:0] squash_hit;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_squash
      assign squash_hit[gi] = i_squash && rob_older(i_squash_robIdx, q_reg[gi].load_robIdx);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      drop_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i] <= '0;
      end
    end else begin
      if (deq) head_reg <= head_reg + 1'b1;
      if (enq) tail_reg <= tail_reg + 1'b1;
      drop_cnt_reg <= drop_cnt_next;
      // A write into the slot being freed this cycle takes priority over the clear.
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (tail_idx == PTR_W'(i))) begin
          q_reg[i] <= new_entry;
        end else if ((deq && (head_idx == PTR_W'(i))) || squash_hit[i]) begin
          q_reg[i].vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_vio_report_queue.sv
// Directed table-driven bench for mem_vio_report_queue, plus reset and
// counter-saturation sequences; expectations follow MEMVIO_DEDUP_EN.
module tb_mem_vio_report_queue;
  import mem_vio_report_queue_pkg::*;

  localparam int FW = FOLDPC_W_DEF;
`ifdef MEMVIO_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             rpt_vld;
  robIdx_t [1:0]          rpt_rob;
  logic [1:0][FW-1:0]     rpt_lf, rpt_sf;
  logic                   squash;
  robIdx_t                squash_rob;
  logic                   vio_vld, vio_rdy, full;
  logic [FW-1:0]          vio_lf, vio_sf;
  logic [3:0]             drop_cnt;

  mem_vio_report_queue #(.NUM_REPORT(2), .DEPTH(4), .FOLDPC_W(FW), .CNT_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_rpt_vld          (rpt_vld),
    .i_rpt_load_robIdx  (rpt_rob),
    .i_rpt_load_foldpc  (rpt_lf),
    .i_rpt_store_foldpc (rpt_sf),
    .i_squash           (squash),
    .i_squash_robIdx    (squash_rob),
    .o_vio_vld          (vio_vld),
    .i_vio_rdy          (vio_rdy),
    .o_vio_load_foldpc  (vio_lf),
    .o_vio_store_foldpc (vio_sf),
    .o_full             (full),
    .o_drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    vld;
    robIdx_t       r0, r1;
    logic [FW-1:0] lf0, sf0, lf1, sf1;
    logic          rdy, sq;
    robIdx_t       sqr;
    logic          e_vld;
    logic [FW-1:0] e_lf, e_sf;
    logic          e_full;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t vecs [32];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic robIdx_t r(input logic f, input int i);
    robIdx_t x;
    x.flg = f;
    x.idx = ROB_IDX_W'(i);
    return x;
  endfunction

  function automatic vec_t mk(input logic [1:0] vld, input robIdx_t r0, input int lf0, input int sf0,
                              input robIdx_t r1, input int lf1, input int sf1, input logic rdy,
                              input logic sq, input robIdx_t sqr, input logic ev, input int elf,
                              input int esf, input logic efull, input int ecnt);
    vec_t v;
    v.vld = vld; v.r0 = r0; v.r1 = r1;
    v.lf0 = FW'(lf0); v.sf0 = FW'(sf0); v.lf1 = FW'(lf1); v.sf1 = FW'(sf1);
    v.rdy = rdy; v.sq = sq; v.sqr = sqr;
    v.e_vld = ev; v.e_lf = FW'(elf); v.e_sf = FW'(esf); v.e_full = efull; v.e_cnt = 4'(ecnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rpt_vld = 2'b00; rpt_rob = '0; rpt_lf = '0; rpt_sf = '0;
    squash = 1'b0; squash_rob = '0; vio_rdy = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic ev, input logic ef, input int ec);
    check({tag, " vld"}, 32'(vio_vld), 32'(ev));
    check({tag, " full"}, 32'(full), 32'(ef));
    check({tag, " cnt"}, 32'(drop_cnt), 32'(ec));
  endtask

  initial begin
    robIdx_t z;
    z = r(0, 0);
    // single report, then pop
    vecs[0]  = mk(2'b01, r(0,5),  'h12,'h34, z,0,0, 1, 0,z, 1,'h12,'h34, 0, 0);
    vecs[1]  = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 0);
    // two reports: older pipe1 kept, pipe0 dropped
    vecs[2]  = mk(2'b11, r(0,9),  'h21,'h22, r(0,3),'h31,'h32, 0, 0,z, 1,'h31,'h32, 0, 1);
    vecs[3]  = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 1);
    // flag wrap: {0,60} is older than {1,2}
    vecs[4]  = mk(2'b11, r(1,2),  'h41,'h42, r(0,60),'h51,'h52, 0, 0,z, 1,'h51,'h52, 0, 2);
    vecs[5]  = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 2);
    // equal robIdx: lowest port wins
    vecs[6]  = mk(2'b11, r(0,7),  'h61,'h62, r(0,7),'h71,'h72, 0, 0,z, 1,'h61,'h62, 0, 3);
    vecs[7]  = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 3);
    // fill to full, overflow drop, then accept on pop
    vecs[8]  = mk(2'b01, r(0,10), 'h80,'h90, z,0,0, 0, 0,z, 1,'h80,'h90, 0, 3);
    vecs[9]  = mk(2'b01, r(0,11), 'h81,'h91, z,0,0, 0, 0,z, 1,'h80,'h90, 0, 3);
    vecs[10] = mk(2'b01, r(0,12), 'h82,'h92, z,0,0, 0, 0,z, 1,'h80,'h90, 0, 3);
    vecs[11] = mk(2'b01, r(0,13), 'h83,'h93, z,0,0, 0, 0,z, 1,'h80,'h90, 1, 3);
    vecs[12] = mk(2'b01, r(0,14), 'h84,'h94, z,0,0, 0, 0,z, 1,'h80,'h90, 1, 4);
    vecs[13] = mk(2'b01, r(0,15), 'h85,'h95, z,0,0, 1, 0,z, 1,'h81,'h91, 1, 4);
    vecs[14] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 1,'h82,'h92, 0, 4);
    vecs[15] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 1,'h83,'h93, 0, 4);
    vecs[16] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 1,'h85,'h95, 0, 4);
    vecs[17] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 4);
    // squash {0,8}: {0,12} skipped silently
    vecs[18] = mk(2'b01, r(0,4),  'hA4,'hB4, z,0,0, 0, 0,z, 1,'hA4,'hB4, 0, 4);
    vecs[19] = mk(2'b01, r(0,8),  'hA8,'hB8, z,0,0, 0, 0,z, 1,'hA4,'hB4, 0, 4);
    vecs[20] = mk(2'b01, r(0,12), 'hAC,'hBC, z,0,0, 0, 0,z, 1,'hA4,'hB4, 0, 4);
    vecs[21] = mk(2'b00, z,0,0,   z,0,0,              0, 1,r(0,8), 1,'hA4,'hB4, 0, 4);
    vecs[22] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 1,'hA8,'hB8, 0, 4);
    vecs[23] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 4);
    vecs[24] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 4);
    // same-cycle squash of incoming: younger discarded uncounted, equal kept
    vecs[25] = mk(2'b01, r(0,20), 'hC0,'hD0, z,0,0, 0, 1,r(0,15), 0,0,0,   0, 4);
    vecs[26] = mk(2'b01, r(0,15), 'hC5,'hD5, z,0,0, 0, 1,r(0,15), 1,'hC5,'hD5, 0, 4);
    vecs[27] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, 4);
    // repeated pair 0x12/0x34
    vecs[28] = mk(2'b01, r(0,30), 'h12,'h34, z,0,0, 0, 0,z, 1,'h12,'h34, 0, 4);
    vecs[29] = mk(2'b01, r(0,31), 'h12,'h34, z,0,0, 0, 0,z, 1,'h12,'h34, 0, DEDUP ? 5 : 4);
    vecs[30] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, !DEDUP,'h12,'h34, 0, DEDUP ? 5 : 4);
    vecs[31] = mk(2'b00, z,0,0,   z,0,0,              1, 0,z, 0,0,0,       0, DEDUP ? 5 : 4);

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 1'b0, 1'b0, 0);

    for (int i = 0; i < 32; i++) begin
      rpt_vld = vecs[i].vld;
      rpt_rob[0] = vecs[i].r0;  rpt_rob[1] = vecs[i].r1;
      rpt_lf[0]  = vecs[i].lf0; rpt_sf[0]  = vecs[i].sf0;
      rpt_lf[1]  = vecs[i].lf1; rpt_sf[1]  = vecs[i].sf1;
      vio_rdy = vecs[i].rdy; squash = vecs[i].sq; squash_rob = vecs[i].sqr;
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_full, int'(vecs[i].e_cnt));
      if (vecs[i].e_vld) begin
        check($sformatf("vec%0d lfpc", i), 32'(vio_lf), 32'(vecs[i].e_lf));
        check($sformatf("vec%0d sfpc", i), 32'(vio_sf), 32'(vecs[i].e_sf));
      end
    end

    // reset while entries are queued discards them
    idle();
    rpt_vld = 2'b01; rpt_rob[0] = r(0,40); rpt_lf[0] = FW'('h55); rpt_sf[0] = FW'('h66);
    tick();
    rpt_rob[0] = r(0,41);
    tick();
    idle();
    check("midrst pre vld", 32'(vio_vld), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_state("midrst", 1'b0, 1'b0, 0);
    vio_rdy = 1'b1;
    tick();
    check("midrst post vld", 32'(vio_vld), 32'd0);

    // drop counter saturation with a stalled consumer
    idle();
    rpt_vld = 2'b11; rpt_rob[0] = r(0,1); rpt_rob[1] = r(0,2);
    rpt_lf[0] = FW'('h1); rpt_sf[0] = FW'('h2); rpt_lf[1] = FW'('h3); rpt_sf[1] = FW'('h4);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 3) check_state("sat c3", 1'b1, 1'b0, 3);
      if (c == 6) check_state("sat c6", 1'b1, 1'b1, 8);
    end
    check_state("sat end", 1'b1, 1'b1, 15);
    check("sat head lfpc", 32'(vio_lf), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
